tristate_bus_sequencer: RTL and testbench
=========================================

Name: tristate_bus_sequencer

Overview:
- Upstream stage for the 8-bit OBUFT output bank: converts the serial input into a parallel word and generates each pad's I (data) and T (tristate) controls.
- Sequences a glitch-free drive window: data is set up while still high-Z, then driven for a fixed time, then released with data held.
- Pads are high-Z at reset and whenever no word is being driven.

Parameters:
- WIDTH, 8, bus width and number of serial bits per word.
- TURN_CYCLES, 1, cycles of setup before driving and hold after release; must be >= 1.
- DRIVE_CYCLES, 4, cycles the bus is actively driven; must be >= 1.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_a  input  1  serial data bit, sent LSB first.
- i_valid  input  1  i_a is sampled on any cycle where this is 1.
- o_d  output  WIDTH  per-pad data, drives OBUFT I.
- o_t  output  WIDTH  per-pad tristate control, drives OBUFT T; 1 = high-Z.
- o_busy  output  1  1 in any state other than IDLE.
- o_done  output  1  one-cycle pulse when the sequence returns to IDLE.
- o_ovr  output  1  sticky overrun flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, bit count = 0, shift register = 0.
  - o_d = 0, o_t = all ones, o_busy = 0, o_done = 0, o_ovr = 0.
- All outputs are registered; no combinational path from any input to any output.
- The o_t bits are all equal at all times; no partial drive.
- IDLE:
  - Each cycle with i_valid=1 shifts i_a into bit position [count], then increments count.
  - When the WIDTH-th valid bit is sampled:
    - the full word (including that bit) loads into o_d on the same edge;
    - count clears to 0;
    - state moves to SETUP.
  - o_t = all ones in IDLE.
- SETUP: lasts TURN_CYCLES cycles, o_t = all ones, o_d stable. Then moves to DRIVE.
- DRIVE: lasts DRIVE_CYCLES cycles, o_t = all zeros, o_d stable. Then moves to HOLD.
- HOLD:
  - Lasts TURN_CYCLES cycles, o_t = all ones, o_d still held.
  - Then moves to IDLE; o_done = 1 for exactly the first IDLE cycle.
- o_d keeps the last word in IDLE until the next word loads; it is never cleared except by reset.
- Latency, with the WIDTH-th bit sampled at edge E:
  - o_busy = 1 and SETUP begins after E.
  - o_t falls after edge E+TURN_CYCLES.
  - o_t rises after edge E+TURN_CYCLES+DRIVE_CYCLES.
  - o_done is high after edge E+2*TURN_CYCLES+DRIVE_CYCLES.
- Overrun: i_valid=1 in SETUP, DRIVE or HOLD:
  - the bit is discarded and count is unchanged;
  - o_ovr is set and stays 1 until reset.
- A valid bit on the same cycle o_done is high is accepted normally (IDLE), counting as bit 0 of the next word.
- Partial words: while i_valid is low, count holds indefinitely; there is no timeout.
- Reset mid-sequence:
  - o_t goes to all ones immediately (asynchronous), which releases the bus at once;
  - the partial word is lost.
- Cycle counter width: clog2(max(TURN_CYCLES, DRIVE_CYCLES)+1). The counter reloads on every state entry.

Test Plan:
- Reset check: assert i_rst_n=0 mid-clock -> immediately o_t=8'hFF, o_d=8'h00, o_busy=0, o_ovr=0.
- Word 0xA5 (bits 1,0,1,0,0,1,0,1), i_valid=1 for 8 consecutive cycles, default parameters:
  - o_d=8'hA5 after the 8th edge;
  - o_t=8'hFF for 1 cycle, then 8'h00 for 4 cycles, then 8'hFF for 1 cycle;
  - o_done pulses once, o_busy high for 6 cycles.
- Gapped input: send 0x3C with i_valid toggled every other cycle -> same drive window as above, measured from the 8th valid bit; o_d=8'h3C.
- Overrun: after word 0xFF, drive i_valid=1 during DRIVE -> o_ovr=1 and o_d stays 8'hFF. Next 8 bits in IDLE of 0x01 -> o_d=8'h01; o_ovr still 1.
- Back-to-back words: first bit of word 0x81 asserted on the o_done cycle -> it is accepted as bit 0; the second drive window shows o_d=8'h81.
- Reset during DRIVE: o_t goes 8'hFF asynchronously. After release, a fresh word 0x5A -> a normal sequence with no leftover bits.

Source files
------------

// File: rtl/tristate_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tristate_bus_sequencer
// Purpose  : Serial-to-parallel front end for an OBUFT bank. It produces the
//            per-pad data and tristate controls for a setup/drive/hold window.
// Revision : 1.0 - initial release
// ============================================================================
module tristate_bus_sequencer #(
    parameter int WIDTH        = 8,
    parameter int TURN_CYCLES  = 1,
    parameter int DRIVE_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_a,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_d,
    output logic [WIDTH-1:0] o_t,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovr
);

    localparam int c_max_cyc = (TURN_CYCLES > DRIVE_CYCLES) ? TURN_CYCLES : DRIVE_CYCLES;
    localparam int c_cw      = $clog2(c_max_cyc + 1);
    localparam int c_bw      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_bw-1:0] c_last_bit = c_bw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_turn_ld  = c_cw'(TURN_CYCLES - 1);
    localparam logic [c_cw-1:0] c_drive_ld = c_cw'(DRIVE_CYCLES - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_setup = 2'd1;
    localparam logic [1:0] c_drive = 2'd2;
    localparam logic [1:0] c_hold  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_cw-1:0]  r_cnt;
    logic [c_cw-1:0]  w_cnt_ld;
    logic [c_bw-1:0]  r_bcnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] w_t_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_ovr;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_overrun;

    assign w_accept  = i_valid && (r_state == c_idle);
    assign w_last    = w_accept && (r_bcnt == c_last_bit);
    assign w_overrun = i_valid && (r_state != c_idle);

    // The completed word includes the bit sampled on this very edge.
    always_comb begin
        w_word         = r_shift;
        w_word[r_bcnt] = i_a;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_last)        w_next_state = c_setup;
            c_setup: if (r_cnt == '0)   w_next_state = c_drive;
            c_drive: if (r_cnt == '0)   w_next_state = c_hold;
            c_hold:  if (r_cnt == '0)   w_next_state = c_idle;
            default:                    w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values, registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_t_nxt    = (w_next_state == c_drive) ? '0 : '1;
        w_busy_nxt = (w_next_state != c_idle);
        w_done_nxt = (r_state == c_hold) && (w_next_state == c_idle);
        case (w_next_state)
            c_setup: w_cnt_ld = c_turn_ld;
            c_drive: w_cnt_ld = c_drive_ld;
            c_hold:  w_cnt_ld = c_turn_ld;
            default: w_cnt_ld = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_d     <= '0;
        end else begin
            if (w_next_state != r_state) begin
                r_cnt <= w_cnt_ld;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_cw'(1);
            end

            if (w_accept) begin
                r_shift[r_bcnt] <= i_a;
                r_bcnt          <= w_last ? '0 : r_bcnt + c_bw'(1);
            end

            if (w_last) begin
                r_d <= w_word;
            end
        end
    end

    // Reset forces every pad to high-Z immediately, releasing the bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t    <= '1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_t    <= w_t_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_ovr  <= r_ovr | w_overrun;
        end
    end

    assign o_d    = r_d;
    assign o_t    = r_t;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_ovr  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tristate_bus_sequencer
// Purpose  : Directed self-checking bench for tristate_bus_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_sequencer;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       valid;
    logic [7:0] d;
    logic [7:0] t;
    logic       busy;
    logic       done;
    logic       ovr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_t;
    logic       exp_b;
    logic       exp_dn;

    tristate_bus_sequencer #(
        .WIDTH        (8),
        .TURN_CYCLES  (1),
        .DRIVE_CYCLES (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_a     (a),
        .i_valid (valid),
        .o_d     (d),
        .o_t     (t),
        .o_busy  (busy),
        .o_done  (done),
        .o_ovr   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_word(input logic [7:0] w, input bit gap);
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            a     = w[i];
            @(negedge clk);
            if (gap && i < 7) begin
                valid = 1'b0;
                @(negedge clk);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        valid = 1'b0;
        a     = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        if (t !== 8'hFF || d !== 8'h00 || busy !== 1'b0 || ovr !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got t=%h d=%h busy=%b ovr=%b done=%b, expected t=ff d=00 busy=0 ovr=0 done=0",
                     t, d, busy, ovr, done);
        end
        n_cmp++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_a5;
        send_word(8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_t  = (i >= 1 && i <= 4) ? 8'h00 : 8'hFF;
            exp_b  = (i <= 5);
            exp_dn = (i == 6);
            if (t !== exp_t || busy !== exp_b || done !== exp_dn || d !== 8'hA5) begin
                n_bad++;
                $display("FAIL a5_window[%0d]: got t=%h busy=%b done=%b d=%h, expected t=%h busy=%b done=%b d=a5",
                         i, t, busy, done, d, exp_t, exp_b, exp_dn);
            end
            n_cmp++;
            @(negedge clk);
        end
    endtask

    task automatic test_gapped;
        send_word(8'h3C, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_t  = (i >= 1 && i <= 4) ? 8'h00 : 8'hFF;
            exp_b  = (i <= 5);
            exp_dn = (i == 6);
            if (t !== exp_t || busy !== exp_b || done !== exp_dn || d !== 8'h3C) begin
                n_bad++;
                $display("FAIL gapped_window[%0d]: got t=%h busy=%b done=%b d=%h, expected t=%h busy=%b done=%b d=3c",
                         i, t, busy, done, d, exp_t, exp_b, exp_dn);
            end
            n_cmp++;
            @(negedge clk);
        end
    endtask

    task automatic test_overrun;
        send_word(8'hFF, 1'b0);
        @(negedge clk);
        if (t !== 8'h00 || ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_pre: got t=%h ovr=%b, expected t=00 ovr=0", t, ovr);
        end
        n_cmp++;
        valid = 1'b1;
        a     = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        if (ovr !== 1'b1 || d !== 8'hFF || t !== 8'h00) begin
            n_bad++;
            $display("FAIL ovr_set: got ovr=%b d=%h t=%h, expected ovr=1 d=ff t=00", ovr, d, t);
        end
        n_cmp++;
        repeat (5) @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_idle: got busy=%b done=%b ovr=%b, expected busy=0 done=0 ovr=1", busy, done, ovr);
        end
        n_cmp++;
        send_word(8'h01, 1'b0);
        if (d !== 8'h01 || ovr !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_next_word: got d=%h ovr=%b busy=%b, expected d=01 ovr=1 busy=1", d, ovr, busy);
        end
        n_cmp++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        send_word(8'h42, 1'b0);
        repeat (6) @(negedge clk);
        if (done !== 1'b1 || d !== 8'h42) begin
            n_bad++;
            $display("FAIL b2b_done: got done=%b d=%h, expected done=1 d=42", done, d);
        end
        n_cmp++;
        send_word(8'h81, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_t  = (i >= 1 && i <= 4) ? 8'h00 : 8'hFF;
            exp_b  = (i <= 5);
            exp_dn = (i == 6);
            if (t !== exp_t || busy !== exp_b || done !== exp_dn || d !== 8'h81) begin
                n_bad++;
                $display("FAIL b2b_window[%0d]: got t=%h busy=%b done=%b d=%h, expected t=%h busy=%b done=%b d=81",
                         i, t, busy, done, d, exp_t, exp_b, exp_dn);
            end
            n_cmp++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_drive;
        send_word(8'h99, 1'b0);
        @(negedge clk);
        if (t !== 8'h00 || d !== 8'h99) begin
            n_bad++;
            $display("FAIL rst_drive_pre: got t=%h d=%h, expected t=00 d=99", t, d);
        end
        n_cmp++;
        #2;
        rst_n = 1'b0;
        #1;
        if (t !== 8'hFF || d !== 8'h00 || busy !== 1'b0 || ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_drive_async: got t=%h d=%h busy=%b ovr=%b, expected t=ff d=00 busy=0 ovr=0",
                     t, d, busy, ovr);
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        // Leave a partial word behind, then reset again to discard it.
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            a     = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(8'h5A, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_t  = (i >= 1 && i <= 4) ? 8'h00 : 8'hFF;
            exp_b  = (i <= 5);
            exp_dn = (i == 6);
            if (t !== exp_t || busy !== exp_b || done !== exp_dn || d !== 8'h5A) begin
                n_bad++;
                $display("FAIL rst_fresh_window[%0d]: got t=%h busy=%b done=%b d=%h, expected t=%h busy=%b done=%b d=5a",
                         i, t, busy, done, d, exp_t, exp_b, exp_dn);
            end
            n_cmp++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_word_a5;
        test_gapped;
        test_overrun;
        test_back_to_back;
        test_reset_in_drive;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
